// File: rtl/bpu_tournament_pkg.sv
// Shared defaults for the tournament branch predictor.
// Define BPU_GSHARE_EN to XOR the local PC index into the global history index.
package bpu_tournament_pkg;

    localparam int unsigned BPU_IDX_BIT  = 6;
    localparam int unsigned BPU_HIST_BIT = 6;
    localparam int unsigned BPU_CNT_BIT  = 2;

`ifdef BPU_GSHARE_EN
    localparam bit BPU_GSHARE = 1'b1;
`else
    localparam bit BPU_GSHARE = 1'b0;
`endif

    // Weakly not-taken value: one below the MSB-set threshold.
    function automatic int unsigned bpu_weak_nt(input int unsigned cnt_bit);
        return (32'd1 << (cnt_bit - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bpu_counter_table.sv
// Array of saturating counters with one combinational read port and one
// saturating inc/dec write port; synchronous reset reloads every entry.
module bpu_counter_table
    import bpu_tournament_pkg::*;
#(
    parameter int unsigned DEPTH_BIT = BPU_IDX_BIT,
    parameter int unsigned CNT_BIT   = BPU_CNT_BIT,
    parameter int unsigned RST_VAL   = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DEPTH_BIT-1:0] i_rd_idx,
    output logic [CNT_BIT-1:0]   o_rd_cnt_c,
    input  logic                 i_we,
    input  logic [DEPTH_BIT-1:0] i_wr_idx,
    input  logic                 i_inc
);

    localparam int unsigned        DEPTH   = 32'd1 << DEPTH_BIT;
    localparam logic [CNT_BIT-1:0] CNT_MAX = '1;
    localparam logic [CNT_BIT-1:0] CNT_RST = CNT_BIT'(RST_VAL);

    logic [CNT_BIT-1:0] r_cnt [DEPTH];
    logic [CNT_BIT-1:0] w_cur;
    logic [CNT_BIT-1:0] w_nxt;

    assign o_rd_cnt_c = r_cnt[i_rd_idx];
    assign w_cur      = r_cnt[i_wr_idx];

    // Saturating step toward the trained direction.
    always_comb begin
        w_nxt = w_cur;
        if (i_inc) begin
            if (w_cur != CNT_MAX) w_nxt = w_cur + CNT_BIT'(1);
        end else begin
            if (w_cur != '0) w_nxt = w_cur - CNT_BIT'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_cnt[i] <= CNT_RST;
        end else if (i_we) begin
            r_cnt[i_wr_idx] <= w_nxt;
        end
    end

endmodule

// File: rtl/bpu_tournament.sv
// Tournament predictor: global + local saturating-counter tables arbitrated by
// a PC-indexed selector. BPU_GSHARE_EN selects gshare global indexing.
module bpu_tournament
    import bpu_tournament_pkg::*;
#(
    parameter int unsigned IDX_BIT  = BPU_IDX_BIT,
    parameter int unsigned HIST_BIT = BPU_HIST_BIT,
    parameter int unsigned CNT_BIT  = BPU_CNT_BIT
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [31:0]         inst_addr,
    input  logic                br_req,
    input  logic                br_res,
    input  logic [HIST_BIT-1:0] br_g_ind,
    input  logic [IDX_BIT-1:0]  br_l_ind,
    input  logic                br_g_pred,
    input  logic                br_l_pred,
    output logic                pred_out,
    output logic [HIST_BIT-1:0] g_ind_out,
    output logic [IDX_BIT-1:0]  l_ind_out,
    output logic                g_pred_out,
    output logic                l_pred_out
);

    localparam int unsigned TAB_RST = bpu_weak_nt(CNT_BIT);

    logic [HIST_BIT-1:0] r_hist;
    logic [IDX_BIT-1:0]  w_l_ind;
    logic [HIST_BIT-1:0] w_g_ind;
    logic [CNT_BIT-1:0]  w_g_cnt;
    logic [CNT_BIT-1:0]  w_l_cnt;
    logic [CNT_BIT-1:0]  w_sel_cnt;
    logic                w_upd;
    logic                w_sel_we;
    logic                w_unused_addr;

    assign w_l_ind       = inst_addr[IDX_BIT+1:2];
    assign w_g_ind       = BPU_GSHARE ? (r_hist ^ HIST_BIT'(w_l_ind)) : r_hist;
    assign w_unused_addr = ^{inst_addr[31:IDX_BIT+2], inst_addr[1:0]};

    assign w_upd    = br_req & rdy_in;
    assign w_sel_we = w_upd & (br_g_pred != br_l_pred);

    assign g_ind_out  = w_g_ind;
    assign l_ind_out  = w_l_ind;
    assign g_pred_out = w_g_cnt[CNT_BIT-1];
    assign l_pred_out = w_l_cnt[CNT_BIT-1];
    assign pred_out   = w_sel_cnt[CNT_BIT-1] ? w_g_cnt[CNT_BIT-1] : w_l_cnt[CNT_BIT-1];

    // Global branch history, shifted in at commit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hist <= '0;
        end else if (w_upd) begin
            r_hist <= {r_hist[HIST_BIT-2:0], br_res};
        end
    end

    bpu_counter_table #(
        .DEPTH_BIT (HIST_BIT),
        .CNT_BIT   (CNT_BIT),
        .RST_VAL   (TAB_RST)
    ) u_g_tab (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_rd_idx   (w_g_ind),
        .o_rd_cnt_c (w_g_cnt),
        .i_we       (w_upd),
        .i_wr_idx   (br_g_ind),
        .i_inc      (br_res)
    );

    bpu_counter_table #(
        .DEPTH_BIT (IDX_BIT),
        .CNT_BIT   (CNT_BIT),
        .RST_VAL   (TAB_RST)
    ) u_l_tab (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_rd_idx   (w_l_ind),
        .o_rd_cnt_c (w_l_cnt),
        .i_we       (w_upd),
        .i_wr_idx   (br_l_ind),
        .i_inc      (br_res)
    );

    // Selector leans global when the global component was the one that was right.
    bpu_counter_table #(
        .DEPTH_BIT (IDX_BIT),
        .CNT_BIT   (CNT_BIT),
        .RST_VAL   (0)
    ) u_sel_tab (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_rd_idx   (w_l_ind),
        .o_rd_cnt_c (w_sel_cnt),
        .i_we       (w_sel_we),
        .i_wr_idx   (br_l_ind),
        .i_inc      (br_g_pred == br_res)
    );

endmodule
